// File: rtl/ddr_app_mem_model.sv
// ddr_app_mem_model: on-chip stand-in for a DDR controller app interface.
// Commands and write data are queued separately and executed strictly in order
// against an inferred block RAM. Writes are byte-masked. Reads return in order
// after the RAM read plus RD_LAT pipeline stages.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   init_calib_complete : high INIT_CYCLES cycles after reset release
//   app_addr/cmd/en/rdy : command channel (cmd 0 = write, 1 = read, else no-op)
//   app_wdf_*           : write-data channel (mask bit 1 = byte not written)
//   app_rd_data*        : read return, one valid pulse per read
module ddr_app_mem_model #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned ADDR_LSB    = 3,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned WDF_DEPTH   = 4,
  parameter int unsigned INIT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_calib_complete,
  input  logic [ADDR_W-1:0]     app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  // Storage is rounded up to at least two entries so pointers are never zero width;
  // the occupancy limit is still CMD_DEPTH / WDF_DEPTH.
  localparam int unsigned CQ_AW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned WQ_AW  = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int unsigned CQ_N   = 1 << CQ_AW;
  localparam int unsigned WQ_N   = 1 << WQ_AW;
  localparam int unsigned CQ_CW  = CQ_AW + 1;
  localparam int unsigned WQ_CW  = WQ_AW + 1;
  localparam int unsigned CAL_W  = $clog2(INIT_CYCLES + 1);
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  // command queue
  logic [DEPTH_LOG2-1:0] cq_idx [CQ_N];
  logic [2:0]            cq_cmd [CQ_N];
  logic [CQ_AW-1:0]      cq_wp, cq_rp;
  logic [CQ_CW-1:0]      cq_cnt, cq_cnt_nxt;

  // write-data FIFO
  logic [DATA_W-1:0]     wq_data [WQ_N];
  logic [MASK_W-1:0]     wq_mask [WQ_N];
  logic [WQ_AW-1:0]      wq_wp, wq_rp;
  logic [WQ_CW-1:0]      wq_cnt, wq_cnt_nxt;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [CAL_W-1:0]      cal_cnt;
  logic                  calib_nxt;

  logic [DATA_W-1:0]     ram_q;
  logic                  ram_vld;
  logic [DATA_W-1:0]     pipe_d [RD_LAT];
  logic [RD_LAT-1:0]     pipe_v;

  logic                  cmd_push, wdf_push, cmd_pop, do_wr, do_rd;
  logic [2:0]            head_cmd;
  logic [DEPTH_LOG2-1:0] head_idx;

  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr};

  // Handshakes, head execution and next-state counts
  always_comb begin
    cmd_push   = app_en & app_rdy;
    wdf_push   = app_wdf_wren & app_wdf_rdy;
    head_cmd   = cq_cmd[cq_rp];
    head_idx   = cq_idx[cq_rp];
    // a write head waits for its data beat; reads and no-ops never stall
    cmd_pop    = !rst && (cq_cnt != '0) && ((head_cmd != CMD_WR) || (wq_cnt != '0));
    do_wr      = cmd_pop && (head_cmd == CMD_WR);
    do_rd      = cmd_pop && (head_cmd == CMD_RD);
    cq_cnt_nxt = cq_cnt + CQ_CW'(cmd_push) - CQ_CW'(cmd_pop);
    wq_cnt_nxt = wq_cnt + WQ_CW'(wdf_push) - WQ_CW'(do_wr);
    calib_nxt  = init_calib_complete || (cal_cnt == CAL_W'(INIT_CYCLES - 1));
  end

  // Control state, calibration and read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      init_calib_complete <= 1'b0;
      cal_cnt             <= '0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      cq_wp               <= '0;
      cq_rp               <= '0;
      cq_cnt              <= '0;
      wq_wp               <= '0;
      wq_rp               <= '0;
      wq_cnt              <= '0;
      ram_vld             <= 1'b0;
      pipe_v              <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
    end else begin
      init_calib_complete <= calib_nxt;
      if (!init_calib_complete) cal_cnt <= cal_cnt + CAL_W'(1);
      // ready flags are registered images of next-cycle occupancy
      app_rdy     <= calib_nxt && (cq_cnt_nxt < CQ_CW'(CMD_DEPTH));
      app_wdf_rdy <= calib_nxt && (wq_cnt_nxt < WQ_CW'(WDF_DEPTH));
      if (cmd_push) cq_wp <= cq_wp + CQ_AW'(1);
      if (cmd_pop)  cq_rp <= cq_rp + CQ_AW'(1);
      if (wdf_push) wq_wp <= wq_wp + WQ_AW'(1);
      if (do_wr)    wq_rp <= wq_rp + WQ_AW'(1);
      cq_cnt  <= cq_cnt_nxt;
      wq_cnt  <= wq_cnt_nxt;
      ram_vld <= do_rd;
      // data stages load only on valid so the output holds between pulses
      pipe_v[0] <= ram_vld;
      if (ram_vld) pipe_d[0] <= ram_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  // Queue storage, no reset needed
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_idx[cq_wp] <= app_addr[ADDR_LSB +: DEPTH_LOG2];
      cq_cmd[cq_wp] <= app_cmd;
    end
    if (wdf_push) begin
      wq_data[wq_wp] <= app_wdf_data;
      wq_mask[wq_wp] <= app_wdf_mask;
    end
  end

  // Block RAM with byte enables; contents survive reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!wq_mask[wq_rp][b]) mem[head_idx][b*8 +: 8] <= wq_data[wq_rp][b*8 +: 8];
      end
    end
    if (do_rd) ram_q <= mem[head_idx];
  end

  assign app_rd_data       = pipe_d[RD_LAT-1];
  assign app_rd_data_valid = pipe_v[RD_LAT-1];
  assign app_rd_data_end   = pipe_v[RD_LAT-1];

endmodule
